adventure_rooms: RTL and testbench
==================================

# adventure_rooms

Room-navigation state machine for the Lab 5 adventure game, and the other end of the sword handshake. It tracks the player's room from four direction buttons and drives `sw` high while the player is in the Secret Sword Stash. It consumes the sword-holder block's `v` (sword held) flag to decide the outcome in the Dragon's Den. It sits between the debounced button inputs and the LED/7-segment display logic.

## Interface
- `CNT_W`, default 8: width of the move counter (used only with the counter configuration).

- `clk`, input, 1: single system clock; everything is clocked on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `n`, `s`, `e`, `w`, input, 1 each: direction buttons, level inputs.
- `v`, input, 1: sword-held flag from the sword block.
- `room`, output, 7: one-hot current room.
  - bit0 CAVE, bit1 TUNNEL, bit2 RIVER, bit3 STASH, bit4 DEN, bit5 VAULT, bit6 GRAVE.
- `sw`, output, 1: high while `room` is STASH; feeds the sword block.
- `win`, output, 1: high while `room` is VAULT.
- `dead`, output, 1: high while `room` is GRAVE.
- `moves`, output, `CNT_W`: accepted-move count.

## Operation
- **Edge detection.** Each direction input has a previous-value register. A press is `x & ~x_prev`. Only presses move the player; a held button yields exactly one move.
- **Press priority.** When several presses occur in one cycle, only the highest-priority one is considered: N > S > E > W. Lower presses that cycle are discarded, not queued.
- **Transitions.** A press with no listed exit leaves the room unchanged.
  - CAVE: E→TUNNEL.
  - TUNNEL: S→RIVER, W→CAVE.
  - RIVER: N→TUNNEL, W→STASH, E→DEN.
  - STASH: E→RIVER.
  - DEN: ignores buttons. Next cycle goes to VAULT if `v`=1, else GRAVE.
  - VAULT, GRAVE: terminal. All presses are ignored until `reset`.
- **Output decode.** `sw`, `win`, `dead` are pure decodes of the room register; no extra latency.
- **Accepted move.** A press that changes `room`. The DEN→VAULT/GRAVE step is not a move.

## Timing
- **Reset.** With `reset`=1 at a rising edge:
  - `room`=7'b0000001 (CAVE); `sw`=`win`=`dead`=0; `moves`=0.
  - Each `x_prev` loads the current `x`, so a button held through reset does not register a press on release of reset.
- **Move latency.** A press sampled at edge k updates `room` at edge k+1. A press is visible on its input during cycle k; `room` changes after the following edge.
- **Sword handshake.**
  - `sw` is high for every cycle `room`=STASH.
  - The sword block latches on `sw`; `v` is combinational from its next-state, so `v` is valid in the same cycle `sw` is high.
- **Dragon's Den.**
  - `room`=DEN lasts exactly one cycle.
  - `v` is sampled at the edge that leaves DEN. A `v` that rises on that same cycle counts.
- **Reset mid-operation.** Reset in any room, including DEN/VAULT/GRAVE, returns to CAVE at that edge; reset overrides any simultaneous press.
- **Release behaviour.** Button release is never a press. Press and release in one cycle is impossible at the sampling level, so no special handling is needed.

## Configuration
- Macro `ADVENTURE_MOVE_COUNT_EN`.
- **Defined:**
  - `moves` increments by 1 on each accepted move and saturates at 2^`CNT_W`−1 (no wrap).
  - Cleared to 0 by `reset`.
  - Updates on the same edge as `room`.
- **Undefined:** `moves` is tied to 0, no counter flops are generated, and room behaviour is identical.

## Test plan
- **Reset.** Assert `reset` 2 cycles with `e` held, release, hold `e` 3 more cycles → `room`=0000001, `sw`=`win`=`dead`=0 throughout; no move.
- **Unarmed death.** Press E, S, E with `v`=0 → `room` goes 0000010, 0000100, 0010000 (one cycle), then 1000000; `dead`=1. Further presses → no change.
- **Victory.**
  - Press E, S, W → `room`=0001000, `sw`=1.
  - Drive `v`=1 from that cycle on.
  - Press E, E → `room`=0010000, then 0100000; `win`=1, `sw`=0.
- **Held button and priority.** Hold `e` 5 cycles in CAVE → exactly one move to TUNNEL. Then S to RIVER, then pulse `n` and `e` together → N wins; `room`=0000010.
- **Ignored press and reset mid-game.** Press N in CAVE → no change and `moves` unchanged. Reset while in GRAVE with `w` pressed the same cycle → `room`=0000001.
- **Move counter.**
  - With `ADVENTURE_MOVE_COUNT_EN` and `CNT_W`=2: perform 5 accepted TUNNEL↔CAVE moves → `moves` reads 1,2,3,3,3.
  - Without the macro → `moves`=0 always.

Source files
------------

// File: rtl/adventure_rooms_if.sv
// Button, sword-flag and room/status signals of the adventure room navigator.
// The master drives buttons and sword flag; the slave (navigator) drives room status.
interface adventure_rooms_if #(
  parameter int CNT_W = 8
);
  logic             n;
  logic             s;
  logic             e;
  logic             w;
  logic             v;
  logic [6:0]       room;
  logic             sw;
  logic             win;
  logic             dead;
  logic [CNT_W-1:0] moves;

  modport master (
    output n, s, e, w, v,
    input  room, sw, win, dead, moves
  );

  modport slave (
    input  n, s, e, w, v,
    output room, sw, win, dead, moves
  );
endinterface

// File: rtl/adventure_rooms.sv
// Room-navigation FSM for the adventure game; the sword flag decides the Dragon's Den outcome.
// Optional saturating move counter enabled by ADVENTURE_MOVE_COUNT_EN.
module adventure_rooms #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  adventure_rooms_if.slave   bus
);

  typedef enum logic [6:0] {
    CAVE   = 7'b0000001,
    TUNNEL = 7'b0000010,
    RIVER  = 7'b0000100,
    STASH  = 7'b0001000,
    DEN    = 7'b0010000,
    VAULT  = 7'b0100000,
    GRAVE  = 7'b1000000
  } roomE;

  roomE       room_q;
  roomE       room_d;
  logic [3:0] prev_q;
  logic [3:0] press;
  logic       goN;
  logic       goS;
  logic       goE;
  logic       goW;

  // Button order is {n, s, e, w}; prev always tracks the raw level, even in reset.
  assign press = {bus.n, bus.s, bus.e, bus.w} & ~prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      room_q <= CAVE;
    end else begin
      room_q <= room_d;
    end
    prev_q <= {bus.n, bus.s, bus.e, bus.w};
  end

  always_comb begin
    room_d = room_q;
    goN    = press[3];
    goS    = press[2] & ~press[3];
    goE    = press[1] & ~press[3] & ~press[2];
    goW    = press[0] & ~press[3] & ~press[2] & ~press[1];
    case (room_q)
      CAVE: begin
        if (goE) room_d = TUNNEL;
      end
      TUNNEL: begin
        if (goS)      room_d = RIVER;
        else if (goW) room_d = CAVE;
      end
      RIVER: begin
        if (goN)      room_d = TUNNEL;
        else if (goW) room_d = STASH;
        else if (goE) room_d = DEN;
      end
      STASH: begin
        if (goE) room_d = RIVER;
      end
      DEN:     room_d = bus.v ? VAULT : GRAVE;
      VAULT:   room_d = VAULT;
      GRAVE:   room_d = GRAVE;
      default: room_d = CAVE;
    endcase
  end

  assign bus.room = room_q;
  assign bus.sw   = (room_q == STASH);
  assign bus.win  = (room_q == VAULT);
  assign bus.dead = (room_q == GRAVE);

`ifdef ADVENTURE_MOVE_COUNT_EN
  logic [CNT_W-1:0] moves_q;
  logic [CNT_W-1:0] moves_d;
  logic             moveAccepted;

  // Leaving the Den is forced by the sword flag, not a button, so it is not a move.
  always_comb begin
    moveAccepted = (room_d != room_q) && (room_q != DEN);
    moves_d      = moves_q;
    if (moveAccepted && (moves_q != {CNT_W{1'b1}})) begin
      moves_d = moves_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      moves_q <= '0;
    end else begin
      moves_q <= moves_d;
    end
  end

  assign bus.moves = moves_q;
`else
  assign bus.moves = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_adventure_rooms.sv
// Directed self-checking bench for adventure_rooms; expected rooms and move counts are hand-derived.
module tb_adventure_rooms;

`ifdef ADVENTURE_MOVE_COUNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif

  localparam logic [6:0] CAVE   = 7'b0000001;
  localparam logic [6:0] TUNNEL = 7'b0000010;
  localparam logic [6:0] RIVER  = 7'b0000100;
  localparam logic [6:0] STASH  = 7'b0001000;
  localparam logic [6:0] DEN    = 7'b0010000;
  localparam logic [6:0] VAULT  = 7'b0100000;
  localparam logic [6:0] GRAVE  = 7'b1000000;

  logic clk;
  logic reset;
  int   checkCount;
  int   errorCount;
  int   acceptedCount;

  adventure_rooms_if #(.CNT_W(CNT_W)) bus ();

  adventure_rooms #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one input vector, let one rising edge pass, then settle before sampling.
  task automatic applyStimulus(input logic r, input logic nb, input logic sb,
                               input logic eb, input logic wb, input logic vb);
    reset = r;
    bus.n = nb;
    bus.s = sb;
    bus.e = eb;
    bus.w = wb;
    bus.v = vb;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] expMoves();
`ifdef ADVENTURE_MOVE_COUNT_EN
    if (acceptedCount > (2 ** CNT_W) - 1) return (2 ** CNT_W) - 1;
    return acceptedCount;
`else
    return 0;
`endif
  endfunction

  task automatic checkState(input string tag, input logic [6:0] expRoom);
    checkOutput({tag, ".room"},  {25'd0, bus.room}, {25'd0, expRoom});
    checkOutput({tag, ".sw"},    {31'd0, bus.sw},   {31'd0, expRoom == STASH});
    checkOutput({tag, ".win"},   {31'd0, bus.win},  {31'd0, expRoom == VAULT});
    checkOutput({tag, ".dead"},  {31'd0, bus.dead}, {31'd0, expRoom == GRAVE});
    checkOutput({tag, ".moves"}, 32'(bus.moves),    expMoves());
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 0, 0);
    acceptedCount = 0;
  endtask

  initial begin
    checkCount    = 0;
    errorCount    = 0;
    acceptedCount = 0;
    reset = 1'b1;
    bus.n = 1'b0;
    bus.s = 1'b0;
    bus.e = 1'b0;
    bus.w = 1'b0;
    bus.v = 1'b0;

    // Reset with east held, then keep east held: no move may appear.
    applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkState("rstHold", CAVE);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkState("rstRelease", CAVE);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkState("rstIdle", CAVE);

    // Unarmed death: E, S, E with v low.
    applyStimulus(0, 0, 0, 1, 0, 0); acceptedCount++;
    checkState("deathE1", TUNNEL);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkState("deathRel1", TUNNEL);
    applyStimulus(0, 0, 1, 0, 0, 0); acceptedCount++;
    checkState("deathS", RIVER);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0); acceptedCount++;
    checkState("deathDen", DEN);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkState("deathGrave", GRAVE);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkState("graveTerminal", GRAVE);

    // Victory: collect the sword in the stash, then carry it through the den.
    doReset();
    checkState("vicReset", CAVE);
    applyStimulus(0, 0, 0, 1, 0, 0); acceptedCount++;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0); acceptedCount++;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0); acceptedCount++;
    checkState("vicStash", STASH);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkState("vicStashHold", STASH);
    applyStimulus(0, 0, 0, 1, 0, 1); acceptedCount++;
    checkState("vicRiver", RIVER);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1); acceptedCount++;
    checkState("vicDen", DEN);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkState("vicVault", VAULT);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkState("vaultTerminal", VAULT);

    // Held button yields one move; simultaneous N and E resolve to N.
    doReset();
    applyStimulus(0, 0, 0, 1, 0, 0); acceptedCount++;
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0, 0);
    checkState("heldE", TUNNEL);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0); acceptedCount++;
    checkState("prioRiver", RIVER);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 0); acceptedCount++;
    checkState("prioN", TUNNEL);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Ignored press in the cave, then reset from the grave with west pressed.
    doReset();
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkState("caveN", CAVE);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0); acceptedCount++;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0); acceptedCount++;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0); acceptedCount++;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkState("midGrave", GRAVE);
    applyStimulus(1, 0, 0, 0, 1, 0);
    acceptedCount = 0;
    checkState("graveReset", CAVE);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkState("graveResetRel", CAVE);

    // Five accepted TUNNEL/CAVE moves exercise counter saturation.
    doReset();
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) begin
        applyStimulus(0, 0, 0, 1, 0, 0);
        acceptedCount++;
        checkState("cntMoveE", TUNNEL);
      end else begin
        applyStimulus(0, 0, 0, 0, 1, 0);
        acceptedCount++;
        checkState("cntMoveW", CAVE);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
    end
    doReset();
    checkState("cntCleared", CAVE);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
